// File: rtl/crt_sched_pkg.sv
// crt_sched_pkg: shared state encoding, refresh quotas and width helper for the CRT request scheduler
package crt_sched_pkg;

  typedef enum logic [2:0] {IDLE, CRT_REQ, CRT_WAIT, REF_REQ, REF_WAIT} state_t;

  localparam int REF_LINE_3 = 3;
  localparam int REF_LINE_5 = 5;

  function automatic int len_w(input int burst_max);
    return $clog2(burst_max) + 1;
  endfunction

endpackage

// File: rtl/crt_mem_req_sched.sv
// crt_mem_req_sched: per-scan-line CRT fetch and DRAM refresh request scheduler
module crt_mem_req_sched
  import crt_sched_pkg::*;
#(
  parameter int BURST_MAX    = 8,
  parameter int WORDS_W      = 9,
  parameter int REF_DEFER    = 4,
  parameter int REF_PEND_MAX = 7
) (
  input  logic                          t_crt_clk,
  input  logic                          h_reset_n,
  input  logic                          vga_en,
  input  logic                          c_crt_line_end,
  input  logic                          cr11_b6,
  input  logic [WORDS_W-1:0]            line_words,
  input  logic                          clr_ovr,
  input  logic                          mem_ack,
  input  logic                          mem_done,
  output logic                          crt_req,
  output logic [len_w(BURST_MAX)-1:0]   crt_len,
  output logic                          ref_req,
  output logic                          busy,
  output logic                          crt_ovr
);

  localparam int LEN_W  = len_w(BURST_MAX);
  localparam int PEND_W = $clog2(REF_PEND_MAX + REF_LINE_5 + 1);
  localparam int DEF_W  = $clog2(REF_DEFER + 1);

  state_t              state_q;
  logic                line_end_q, crt_ovr_q, crt_req_q, ref_req_q;
  logic [WORDS_W-1:0]  words_left_q, words_left_d;
  logic [PEND_W-1:0]   ref_pend_q, ref_pend_d, pend_sum;
  logic [DEF_W-1:0]    defer_cnt_q, defer_cnt_d;
  logic [LEN_W-1:0]    crt_len_q, burst_len;
  logic                le, crt_done, ref_done, crt_pick, ref_pick;

  assign le        = c_crt_line_end & ~line_end_q & vga_en;
  assign crt_done  = mem_done & (((state_q == CRT_REQ) & mem_ack) | (state_q == CRT_WAIT));
  assign ref_done  = mem_done & (((state_q == REF_REQ) & mem_ack) | (state_q == REF_WAIT));
  assign crt_pick  = vga_en & (words_left_q != '0) &
                     ((ref_pend_q == '0) | (defer_cnt_q < DEF_W'(REF_DEFER)));
  assign ref_pick  = vga_en & (ref_pend_q != '0);
  assign burst_len = (words_left_q > WORDS_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : LEN_W'(words_left_q);

  assign crt_req = crt_req_q;
  assign ref_req = ref_req_q;
  assign crt_len = crt_len_q;
  assign crt_ovr = crt_ovr_q;
  assign busy    = (state_q != IDLE) | (words_left_q != '0) | (ref_pend_q != '0);

  // Next-state of the per-line counters: disable clears, line-end reload beats a burst decrement
  always_comb begin
    pend_sum     = ref_pend_q - PEND_W'(ref_done & (ref_pend_q != '0)) +
                   (le ? PEND_W'(cr11_b6 ? REF_LINE_5 : REF_LINE_3) : '0);
    ref_pend_d   = !vga_en ? '0 : (pend_sum > PEND_W'(REF_PEND_MAX)) ? PEND_W'(REF_PEND_MAX) : pend_sum;
    words_left_d = !vga_en ? '0 : le ? line_words :
                   !crt_done ? words_left_q :
                   (words_left_q > WORDS_W'(crt_len_q)) ? words_left_q - WORDS_W'(crt_len_q) : '0;
    defer_cnt_d  = ref_done ? '0 : !crt_done ? defer_cnt_q :
                   (ref_pend_q != '0) ? defer_cnt_q + DEF_W'(1) : '0;
  end

  // Line-end edge register, work counters and sticky overrun flag (set beats clear)
  always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      line_end_q   <= 1'b0;
      words_left_q <= '0;
      ref_pend_q   <= '0;
      defer_cnt_q  <= '0;
      crt_ovr_q    <= 1'b0;
    end else begin
      line_end_q   <= c_crt_line_end;
      words_left_q <= words_left_d;
      ref_pend_q   <= ref_pend_d;
      defer_cnt_q  <= defer_cnt_d;
      crt_ovr_q    <= (le & (words_left_q != '0)) | (crt_ovr_q & ~clr_ovr);
    end
  end

  // Request FSM: picks CRT or refresh in IDLE and runs one req/ack/done transaction
  always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q   <= IDLE;
      crt_req_q <= 1'b0;
      ref_req_q <= 1'b0;
      crt_len_q <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (crt_pick) begin
            state_q   <= CRT_REQ;
            crt_req_q <= 1'b1;
            crt_len_q <= burst_len;
          end else if (ref_pick) begin
            state_q   <= REF_REQ;
            ref_req_q <= 1'b1;
          end
        CRT_REQ:
          if (mem_ack) begin
            crt_req_q <= 1'b0;
            state_q   <= mem_done ? IDLE : CRT_WAIT;
          end
        CRT_WAIT:
          if (mem_done) state_q <= IDLE;
        REF_REQ:
          if (mem_ack) begin
            ref_req_q <= 1'b0;
            state_q   <= mem_done ? IDLE : REF_WAIT;
          end
        REF_WAIT:
          if (mem_done) state_q <= IDLE;
        default: begin
          state_q   <= IDLE;
          crt_req_q <= 1'b0;
          ref_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crt_mem_req_sched.sv
// tb_crt_mem_req_sched: directed vector table plus multi-cycle sequences for the CRT request scheduler
module tb_crt_mem_req_sched;

  logic       t_crt_clk = 1'b0;
  logic       h_reset_n = 1'b0;
  logic       vga_en = 1'b0, c_crt_line_end = 1'b0, cr11_b6 = 1'b0, clr_ovr = 1'b0;
  logic       mem_ack = 1'b0, mem_done = 1'b0;
  logic [8:0] line_words = '0;
  logic       crt_req, ref_req, busy, crt_ovr;
  logic [3:0] crt_len;

  int errors = 0;
  int checks = 0;
  int got[$];
  int exp_q[$];
  int first_req;
  bit serve_ok;

  typedef struct {
    int en, le, cr, lw, clr, ack, done;
    int creq, len, rreq, bsy, ovr;
  } vec_t;
  vec_t tv[16];

  always #5 t_crt_clk = ~t_crt_clk;

  crt_mem_req_sched #(.BURST_MAX(8), .WORDS_W(9), .REF_DEFER(4), .REF_PEND_MAX(7)) dut (
    .t_crt_clk(t_crt_clk), .h_reset_n(h_reset_n), .vga_en(vga_en),
    .c_crt_line_end(c_crt_line_end), .cr11_b6(cr11_b6), .line_words(line_words),
    .clr_ovr(clr_ovr), .mem_ack(mem_ack), .mem_done(mem_done),
    .crt_req(crt_req), .crt_len(crt_len), .ref_req(ref_req), .busy(busy), .crt_ovr(crt_ovr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int creq, input int len, input int rreq,
                         input int bsy, input int ovr);
    chk({name, ".crt_req"}, int'(crt_req), creq);
    chk({name, ".crt_len"}, int'(crt_len), len);
    chk({name, ".ref_req"}, int'(ref_req), rreq);
    chk({name, ".busy"}, int'(busy), bsy);
    chk({name, ".crt_ovr"}, int'(crt_ovr), ovr);
  endtask

  task automatic tick();
    @(posedge t_crt_clk);
    #1;
    chk("req_exclusive", int'(crt_req && ref_req), 0);
  endtask

  task automatic do_reset();
    h_reset_n = 1'b0;
    vga_en = 1'b1; c_crt_line_end = 1'b0; cr11_b6 = 1'b0; line_words = '0;
    clr_ovr = 1'b0; mem_ack = 1'b0; mem_done = 1'b0;
    repeat (2) @(posedge t_crt_clk);
    #1;
    h_reset_n = 1'b1;
  endtask

  task automatic start_line(input int lw, input int cr);
    line_words = 9'(lw);
    cr11_b6 = (cr != 0);
    c_crt_line_end = 1'b1;
    tick();
    c_crt_line_end = 1'b0;
  endtask

  // Memory-controller model: ack one clk after a request, done one clk after ack
  task automatic serve(input int max_txn);
    got = {};
    first_req = -1;
    serve_ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (crt_req || ref_req) begin
        if (first_req < 0) first_req = c;
        got.push_back(crt_req ? int'(crt_len) : 100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        if (got.size() >= max_txn) begin
          serve_ok = 1'b1;
          break;
        end
      end else if (!busy) begin
        serve_ok = 1'b1;
        break;
      end
      tick();
    end
    chk("serve_finished", int'(serve_ok), 1);
  endtask

  // Transaction codes: CRT bursts log their length, refreshes log 100
  task automatic cmp_seq(input string name);
    chk({name, ".count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s.txn%0d", name, i), got[i], exp_q[i]);
  endtask

  initial begin
    tv = '{
      '{1,0,0, 0,0,0,0,  0,0,0,0,0},
      '{1,1,0,10,0,0,0,  0,0,0,1,0},
      '{1,1,0,10,0,0,0,  1,8,0,1,0},
      '{1,0,0, 0,0,1,0,  0,8,0,1,0},
      '{1,0,0, 0,0,0,1,  0,8,0,1,0},
      '{1,0,0, 0,0,0,0,  1,2,0,1,0},
      '{1,0,0, 0,0,1,1,  0,2,0,1,0},
      '{1,0,0, 0,0,0,0,  0,2,1,1,0},
      '{1,0,0, 0,0,1,0,  0,2,0,1,0},
      '{1,0,0, 0,0,0,1,  0,2,0,1,0},
      '{1,0,0, 0,0,1,0,  0,2,1,1,0},
      '{1,0,0, 0,0,1,1,  0,2,0,1,0},
      '{1,0,0, 0,0,0,1,  0,2,1,1,0},
      '{1,0,0, 0,0,1,0,  0,2,0,1,0},
      '{1,0,0, 0,0,0,1,  0,2,0,0,0},
      '{1,0,0, 0,1,0,0,  0,2,0,0,0}
    };

    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      vga_en = (tv[i].en != 0);
      c_crt_line_end = (tv[i].le != 0);
      cr11_b6 = (tv[i].cr != 0);
      line_words = 9'(tv[i].lw);
      clr_ovr = (tv[i].clr != 0);
      mem_ack = (tv[i].ack != 0);
      mem_done = (tv[i].done != 0);
      tick();
      chk_out($sformatf("vec%0d", i), tv[i].creq, tv[i].len, tv[i].rreq, tv[i].bsy, tv[i].ovr);
    end

    do_reset();
    start_line(20, 0);
    serve(99);
    exp_q = '{8, 8, 4, 100, 100, 100};
    cmp_seq("line20");
    chk("line20.first_req_latency", first_req, 1);
    chk("line20.busy_end", int'(busy), 0);

    do_reset();
    start_line(40, 1);
    serve(99);
    exp_q = '{8, 8, 8, 8, 100, 8, 100, 100, 100, 100};
    cmp_seq("line40_defer");

    do_reset();
    start_line(20, 0);
    serve(1);
    line_words = 9'd30;
    c_crt_line_end = 1'b1;
    tick();
    c_crt_line_end = 1'b0;
    chk("ovr.set", int'(crt_ovr), 1);
    chk("ovr.inflight_req", int'(crt_req), 1);
    serve(99);
    exp_q = '{8, 8, 8, 100, 6, 100, 100, 100, 100, 100};
    cmp_seq("ovr.reload");
    chk("ovr.sticky", int'(crt_ovr), 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr.cleared", int'(crt_ovr), 0);
    start_line(16, 0);
    chk("ovr.empty_reload", int'(crt_ovr), 0);
    tick();
    c_crt_line_end = 1'b1;
    clr_ovr = 1'b1;
    tick();
    c_crt_line_end = 1'b0;
    clr_ovr = 1'b0;
    chk("ovr.set_beats_clr", int'(crt_ovr), 1);
    chk("ovr.req_not_aborted", int'(crt_req), 1);

    do_reset();
    line_words = '0;
    cr11_b6 = 1'b1;
    repeat (3) begin
      c_crt_line_end = 1'b1;
      tick();
      c_crt_line_end = 1'b0;
      tick();
    end
    chk("sat.ref_req_held", int'(ref_req), 1);
    serve(99);
    exp_q = {};
    repeat (7) exp_q.push_back(100);
    cmp_seq("sat");

    do_reset();
    start_line(20, 0);
    tick();
    chk("dis.crt_req", int'(crt_req), 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vga_en = 1'b0;
    tick();
    chk("dis.wait_req", int'(crt_req), 0);
    chk("dis.wait_busy", int'(busy), 1);
    mem_done = 1'b1;
    c_crt_line_end = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("dis.done_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      c_crt_line_end = ~c_crt_line_end;
      tick();
      chk_out($sformatf("dis.idle%0d", i), 0, 8, 0, 0, 0);
    end

    do_reset();
    start_line(20, 0);
    tick();
    chk("rst.req_before", int'(crt_req), 1);
    #2;
    h_reset_n = 1'b0;
    #1;
    chk_out("rst.async", 0, 0, 0, 0, 0);
    repeat (2) tick();
    h_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("rst.after%0d", i), 0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
